// File: rtl/score_accumulator_pkg.sv
// Shared definitions for the score accumulator slice.
//   MAX_NUM         : codebase-wide score/count datapath width
//   ST_*  / state_e : accumulator FSM state encoding
//   MOD_*           : game mode codes latched on start
package score_accumulator_pkg;

    localparam int unsigned MAX_NUM = 32;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StWait = ST_WAIT,
        StAcc  = ST_ACC,
        StDone = ST_DONE
    } state_e;

    localparam logic [1:0] MOD_NORMAL = 2'b00;
    localparam logic [1:0] MOD_NOFAIL = 2'b01;
    localparam logic [1:0] MOD_HALF   = 2'b10;
    localparam logic [1:0] MOD_DOUBLE = 2'b11;

endpackage

// File: rtl/score_accumulator_sat_add.sv
// Three-operand W-bit saturating adder.
//   a, b, c : W-bit unsigned operands
//   sum     : a+b+c, clamped to all-ones when the true sum exceeds W bits
// The sum is formed at W+2 bits so two carries can never be lost.
module sat_add
    import score_accumulator_pkg::*;
#(
    parameter int unsigned W = MAX_NUM
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum
);

    logic [W+1:0] full;

    always_comb begin
        full = {2'b00, a} + {2'b00, b} + {2'b00, c};
        sum  = (|full[W+1:W]) ? '1 : full[W-1:0];
    end

endmodule

// File: rtl/score_accumulator.sv
// Per-song score bookkeeping behind the per-note scoring stage.
// After each accepted note it waits LAT cycles for the scoring stage, captures
// base/bonus/combo, and updates the running totals fed back to that stage.
// Optional build macro: SCORE_ACC_FAIL_EN (miss-limit song failure).
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : begin a new song (clears totals, latches total_note/mod)
//   total_note, mod  : notes in song and game mode, sampled on start
//   hit_valid        : note presented to the scoring stage; hit_ready accepts it
//   base_score, bonus_score, combo : scoring stage results, valid LAT cycles later
//   last_combo, last_base_score, now_cnt : feedback to the scoring stage
//   total_score, max_combo : song totals
//   song_done, failed : song finished / finished by the fail rule
module score_accumulator
    import score_accumulator_pkg::*;
#(
    parameter int unsigned W          = MAX_NUM,
    parameter int unsigned LAT        = 3,
    parameter int unsigned MISS_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] total_note,
    input  logic [1:0]   mod,
    input  logic         hit_valid,
    output logic         hit_ready,
    input  logic [W-1:0] base_score,
    input  logic [W-1:0] bonus_score,
    input  logic [W-1:0] combo,
    output logic [W-1:0] last_combo,
    output logic [W-1:0] last_base_score,
    output logic [W-1:0] now_cnt,
    output logic [W-1:0] total_score,
    output logic [W-1:0] max_combo,
    output logic         song_done,
    output logic         failed
);

    localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CntW-1:0] LatInit = CntW'(LAT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] lat_cnt_q, lat_cnt_d;
    logic [W-1:0]    total_note_q, total_note_d;
    logic [1:0]      mod_q, mod_d;
    logic [W-1:0]    now_cnt_q, now_cnt_d;
    logic [W-1:0]    last_combo_q, last_combo_d;
    logic [W-1:0]    last_base_q, last_base_d;
    logic [W-1:0]    total_q, total_d;
    logic [W-1:0]    max_combo_q, max_combo_d;

    logic [W-1:0]    base_sum, total_sum, now_inc;
    logic            fail_hit;

`ifdef SCORE_ACC_FAIL_EN
    logic [W-1:0]    miss_cnt_q, miss_cnt_d;
    logic            failed_q, failed_d;
`endif

    sat_add #(
        .W (W)
    ) u_sat_base (
        .a   (last_base_q),
        .b   (base_score),
        .c   ('0),
        .sum (base_sum)
    );

    sat_add #(
        .W (W)
    ) u_sat_total (
        .a   (total_q),
        .b   (base_score),
        .c   (bonus_score),
        .sum (total_sum)
    );

    assign now_inc = now_cnt_q + W'(1);

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        total_note_d = total_note_q;
        mod_d        = mod_q;
        now_cnt_d    = now_cnt_q;
        last_combo_d = last_combo_q;
        last_base_d  = last_base_q;
        total_d      = total_q;
        max_combo_d  = max_combo_q;
        fail_hit     = 1'b0;
`ifdef SCORE_ACC_FAIL_EN
        miss_cnt_d   = miss_cnt_q;
        failed_d     = failed_q;
`endif

        if (start) begin
            // start overrides every state; a same-cycle hit_valid is dropped
            state_d      = (total_note == '0) ? StDone : StRun;
            lat_cnt_d    = '0;
            total_note_d = total_note;
            mod_d        = mod;
            now_cnt_d    = '0;
            last_combo_d = '0;
            last_base_d  = '0;
            total_d      = '0;
            max_combo_d  = '0;
`ifdef SCORE_ACC_FAIL_EN
            miss_cnt_d   = '0;
            failed_d     = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hit_valid) begin
                        state_d   = StWait;
                        lat_cnt_d = LatInit;
                    end
                end
                StWait: begin
                    if (lat_cnt_q == '0) begin
                        state_d = StAcc;
                    end else begin
                        lat_cnt_d = lat_cnt_q - CntW'(1);
                    end
                end
                StAcc: begin
                    last_combo_d = combo;
                    max_combo_d  = (combo > max_combo_q) ? combo : max_combo_q;
                    last_base_d  = base_sum;
                    total_d      = total_sum;
                    now_cnt_d    = now_inc;
`ifdef SCORE_ACC_FAIL_EN
                    miss_cnt_d = ((base_score == '0) && (combo == '0)) ?
                                 miss_cnt_q + W'(1) : '0;
                    fail_hit   = (mod_q != MOD_NOFAIL) && (miss_cnt_d >= W'(MISS_LIMIT));
                    failed_d   = fail_hit;
`endif
                    state_d = (fail_hit || (now_inc == total_note_q)) ? StDone : StRun;
                end
                StIdle, StDone: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lat_cnt_q    <= '0;
            total_note_q <= '0;
            mod_q        <= MOD_NORMAL;
            now_cnt_q    <= '0;
            last_combo_q <= '0;
            last_base_q  <= '0;
            total_q      <= '0;
            max_combo_q  <= '0;
`ifdef SCORE_ACC_FAIL_EN
            miss_cnt_q   <= '0;
            failed_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            total_note_q <= total_note_d;
            mod_q        <= mod_d;
            now_cnt_q    <= now_cnt_d;
            last_combo_q <= last_combo_d;
            last_base_q  <= last_base_d;
            total_q      <= total_d;
            max_combo_q  <= max_combo_d;
`ifdef SCORE_ACC_FAIL_EN
            miss_cnt_q   <= miss_cnt_d;
            failed_q     <= failed_d;
`endif
        end
    end

    assign hit_ready       = (state_q == StRun);
    assign song_done       = (state_q == StDone);
    assign last_combo      = last_combo_q;
    assign last_base_score = last_base_q;
    assign now_cnt         = now_cnt_q;
    assign total_score     = total_q;
    assign max_combo       = max_combo_q;

`ifdef SCORE_ACC_FAIL_EN
    assign failed = failed_q;
`else
    // Mode and miss limit only matter to the fail rule.
    logic        unused_mod;
    logic [31:0] unused_miss_limit;
    assign failed            = 1'b0;
    assign unused_mod        = ^mod_q;
    assign unused_miss_limit = MISS_LIMIT;
`endif

endmodule
